// File: rtl/game_countdown_timer.sv
// Tenths-of-a-second BCD countdown timer driven by the 100 ms tick generator.
// Loads tens/ones seconds, counts down with pause and clear, and flags expiry.
module game_countdown_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       ms100,
   output logic       tick_en,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [3:0] tenths,
   output logic       running,
   output logic       low_time,
   output logic       timeout,
   output logic       expired
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   state_t     state, state_nx;
   logic [3:0] tens_nx, ones_nx, tenths_nx;
   logic [3:0] ld_tens, ld_ones;
   logic       timeout_nx;
   logic       last_tick;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign ld_tens   = clamp_bcd(load_tens);
   assign ld_ones   = clamp_bcd(load_ones);
   assign last_tick = (tens == 4'd0) && (ones == 4'd0) && (tenths == 4'd1);

   always_comb begin
      state_nx   = state;
      tens_nx    = tens;
      ones_nx    = ones;
      tenths_nx  = tenths;
      timeout_nx = 1'b0;
      if (clear) begin
         state_nx  = IDLE;
         tens_nx   = 4'd0;
         ones_nx   = 4'd0;
         tenths_nx = 4'd0;
      end else if (start && (state == IDLE || state == EXPIRED)) begin
         tens_nx   = ld_tens;
         ones_nx   = ld_ones;
         tenths_nx = 4'd0;
         if (ld_tens == 4'd0 && ld_ones == 4'd0) begin
            state_nx   = EXPIRED;
            timeout_nx = 1'b1;
         end else begin
            state_nx = RUN;
         end
      end else if (state == RUN) begin
         if (ms100) begin
            // Ripple borrow: each digit that underflows wraps to 9
            if (tenths != 4'd0) begin
               tenths_nx = tenths - 4'd1;
            end else begin
               tenths_nx = 4'd9;
               if (ones != 4'd0) begin
                  ones_nx = ones - 4'd1;
               end else begin
                  ones_nx = 4'd9;
                  tens_nx = tens - 4'd1;
               end
            end
            if (last_tick) begin
               state_nx   = EXPIRED;
               timeout_nx = 1'b1;
            end else if (pause) begin
               state_nx = PAUSE;
            end
         end else if (pause) begin
            state_nx = PAUSE;
         end
      end else if (state == PAUSE) begin
         if (!pause) state_nx = RUN;
      end
   end

   // Status flags are derived from next state so every output is registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tens     <= 4'd0;
         ones     <= 4'd0;
         tenths   <= 4'd0;
         tick_en  <= 1'b0;
         running  <= 1'b0;
         low_time <= 1'b0;
         timeout  <= 1'b0;
         expired  <= 1'b0;
      end else begin
         state    <= state_nx;
         tens     <= tens_nx;
         ones     <= ones_nx;
         tenths   <= tenths_nx;
         tick_en  <= (state_nx == RUN);
         running  <= (state_nx == RUN);
         low_time <= (state_nx == RUN || state_nx == PAUSE) && (tens_nx == 4'd0);
         timeout  <= timeout_nx;
         expired  <= (state_nx == EXPIRED);
      end
   end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Tenths-of-a-second countdown timer that consumes the single-cycle `ms100` pulse from the LFSR 100 ms tick generator and drives that generator's `enable`. It loads a BCD seconds value, counts down by 0.1 s per tick with pause and clear, and reports expiry. It sits between the game control FSM and the 7-segment display path, and provides three BCD digits (tens, ones, tenths).

## Interface
- No parameters.
- `clk`  in  1  system clock; every register is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  single-cycle pulse; loads and starts from IDLE or EXPIRED.
- `pause`  in  1  level; high freezes the count while in RUN or PAUSE.
- `clear`  in  1  single-cycle pulse; aborts to IDLE from any state.
- `load_tens`  in  4  BCD tens-of-seconds load value.
- `load_ones`  in  4  BCD seconds load value.
- `ms100`  in  1  100 ms tick pulse from the generator.
- `tick_en`  out  1  enable to the generator; 1 only in RUN.
- `tens`, `ones`, `tenths`  out  4 each  current BCD time remaining.
- `running`  out  1  1 in RUN.
- `low_time`  out  1  1 in RUN or PAUSE when `tens`==0.
- `timeout`  out  1  single-cycle expiry pulse.
- `expired`  out  1  level; 1 in EXPIRED.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset enters IDLE.
- Reset values: digits 0/0/0; `tick_en`, `running`, `low_time`, `timeout`, `expired` all 0.
- Priority on every edge: `clear` > `start` > `ms100` > `pause`.
- `clear` in any state: go to IDLE, digits 0/0/0, `tick_en` 0.
- Load clamping: a load digit above 9 is clamped to 9. `tenths` is loaded as 0.
- IDLE or EXPIRED with `start`: load digits. If the loaded value is 00.0, go to EXPIRED and pulse `timeout`. Otherwise go to RUN.
- `start` while in RUN or PAUSE is ignored.
- RUN with `ms100`: decrement the 3-digit BCD value.
  - `tenths` 0 borrows from `ones`; `ones` 0 borrows from `tens`. A borrowing digit wraps to 9.
  - If the value was 00.1, it becomes 00.0, `timeout` pulses, and the state goes to EXPIRED.
- RUN with `pause`=1: go to PAUSE. If `ms100` arrives in the same cycle, apply the decrement first.
- PAUSE: `tick_en`=0; `ms100` is ignored. When `pause`=0, return to RUN.
- Dropping `tick_en` resets the generator's internal count, so the partial 100 ms interval is lost on pause. This is accepted behaviour.
- EXPIRED: digits hold 00.0 and `expired`=1 until `start` or `clear`.

## Timing
- All outputs are registered.
- State, digits and `tick_en` update on the edge that samples the event.
- Outputs are visible in the following cycle.
- `timeout` is high for exactly one cycle, the cycle after the final `ms100` (or after a zero-load `start`).
- `tick_en` falls on that same edge.
- After RUN is entered, the first `ms100` arrives 100 ms later, set by the generator. A load of S seconds expires 10·S ticks after `start`.
- `ms100` pulses while not in RUN have no effect.
- Asynchronous reset mid-count: IDLE immediately, digits 0, `tick_en` 0. `start` is needed to run again.

## Test plan
- Reset mid-count: assert `rst`=0 in RUN at 07.3 → outputs go to reset values immediately. After release the block stays in IDLE with `tick_en`=0.
- Basic countdown: load 0/2, `start`, 20 `ms100` pulses → digits step 02.0, 01.9 … 00.1, 00.0. `timeout` is high exactly one cycle after the 20th tick, then `expired`=1 and `tick_en`=0.
- Borrow chain: load 1/0 → first tick gives 09.9 and `low_time`=1. Load 2/0 → first tick gives 19.9 and `low_time`=0.
- Pause with a coincident tick: at 05.0, assert `pause` in the same cycle as `ms100` → shows 04.9 and state PAUSE. Five ticks during PAUSE → still 04.9. Release `pause` → RUN, `tick_en`=1.
- Priority and edge loads:
  - `clear` and `start` in the same cycle in RUN → IDLE, 00.0.
  - Load 0/0 with `start` → `timeout` pulses, state EXPIRED, no `tick_en`.
  - Load 12/15 (invalid BCD) → clamps to 99.0.
- Ignored `start`: `start` while RUN at 03.4 → no reload, countdown continues.
